// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard controller.
package hazard_pkg;

   localparam int unsigned REG_W = 5;

   // EX operand source selects
   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_MEM = 2'b01;
   localparam logic [1:0] FWD_WB  = 2'b10;
   localparam logic [1:0] FWD_RET = 2'b11;

   // Memory wait FSM state encoding
   typedef logic [0:0] mem_state_t;
   localparam mem_state_t ST_IDLE = 1'b0;
   localparam mem_state_t ST_WAIT = 1'b1;

   // One in-flight instruction as tracked by the scoreboard
   typedef struct packed {
      logic             valid;
      logic             wr_en;
      logic [REG_W-1:0] wr_id;
      logic             ld;
      logic             mem;
      logic [REG_W-1:0] rs;
      logic [REG_W-1:0] rt;
      logic             urs;
      logic             urt;
   } slot_t;

   // True when a valid writer targets the given source register
   function automatic logic wr_hit(input logic v, input logic we,
                                   input logic [REG_W-1:0] wid,
                                   input logic [REG_W-1:0] src);
      return v & we & (wid == src);
   endfunction

endpackage

// File: rtl/hazard_mem_fsm.sv
// Data-memory wait tracking: freezes the pipeline while MEM waits, aborts on timeout.
module hazard_mem_fsm
   import hazard_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned TO_W        = 5
) (
   input  logic clk,
   input  logic rst,
   input  logic mem_active,
   input  logic dmem_ready,
   output logic freeze,
   output logic dmem_req,
   output logic mem_err
);

   mem_state_t      state_q, state_d;
   logic [TO_W-1:0] cnt_q, cnt_d;

   // State and wait-counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state, freeze/request/abort decode
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      freeze   = 1'b0;
      dmem_req = 1'b0;
      mem_err  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            dmem_req = mem_active;
            if (mem_active && !dmem_ready) begin
               freeze  = 1'b1;
               state_d = ST_WAIT;
               cnt_d   = TO_W'(1);
            end
         end
         ST_WAIT: begin
            dmem_req = 1'b1;
            if (dmem_ready) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == TO_W'(MEM_TIMEOUT)) begin
               mem_err = !rst;
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               freeze = 1'b1;
               cnt_d  = cnt_q + TO_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing: scoreboard, EX forwarding, stalls, flush and memory freeze.
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned TO_W        = 5
) (
   input  logic             sys_clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs_id,
   input  logic [REG_W-1:0] id_rt_id,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             id_is_jr,
   input  logic             id_reg_write,
   input  logic [REG_W-1:0] id_wr_id,
   input  logic             id_mem_to_reg,
   input  logic             id_mem_write,
   input  logic             ex_redirect,
   input  logic             dmem_ready,
   output logic             stall_if_id,
   output logic             bubble_ex,
   output logic             flush_if_id,
   output logic             freeze,
   output logic             dmem_req,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             mem_err
);

   slot_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, ret_q, ret_d;
   slot_t id_slot;
   logic  load_use, jr_haz;

   hazard_mem_fsm #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .TO_W        (TO_W)
   ) u_mem_fsm (
      .clk        (sys_clk),
      .rst        (rst),
      .mem_active (mem_q.valid & mem_q.mem),
      .dmem_ready (dmem_ready),
      .freeze     (freeze),
      .dmem_req   (dmem_req),
      .mem_err    (mem_err)
   );

   // Scoreboard entry for the instruction in ID; $0 never counts as a write
   always_comb begin
      id_slot       = '0;
      id_slot.valid = id_valid;
      id_slot.wr_en = id_reg_write & (id_wr_id != '0);
      id_slot.wr_id = id_wr_id;
      id_slot.ld    = id_mem_to_reg;
      id_slot.mem   = id_mem_to_reg | id_mem_write;
      id_slot.rs    = id_rs_id;
      id_slot.rt    = id_rt_id;
      id_slot.urs   = id_uses_rs;
      id_slot.urt   = id_uses_rt;
   end

   // Load-use and jr hazards; redirect wins over stall, freeze silences both
   always_comb begin
      stall_if_id = 1'b0;
      bubble_ex   = 1'b0;
      flush_if_id = 1'b0;
      load_use = id_valid & ex_q.valid & ex_q.ld &
                 ((wr_hit(1'b1, ex_q.wr_en, ex_q.wr_id, id_rs_id) & id_uses_rs) |
                  (wr_hit(1'b1, ex_q.wr_en, ex_q.wr_id, id_rt_id) & id_uses_rt));
      jr_haz   = id_valid & id_is_jr &
                 (wr_hit(ex_q.valid, ex_q.wr_en, ex_q.wr_id, id_rs_id) |
                  wr_hit(mem_q.valid, mem_q.wr_en & mem_q.ld, mem_q.wr_id, id_rs_id));
      if (!freeze) begin
         if (ex_redirect) begin
            flush_if_id = 1'b1;
            bubble_ex   = 1'b1;
         end else if (load_use || jr_haz) begin
            stall_if_id = 1'b1;
            bubble_ex   = 1'b1;
         end
      end
   end

   // EX operand forwarding, youngest producer first; loads never forward from MEM
   always_comb begin
      fwd_a = FWD_REG;
      fwd_b = FWD_REG;
      if (ex_q.valid && ex_q.urs) begin
         if (wr_hit(mem_q.valid, mem_q.wr_en & !mem_q.ld, mem_q.wr_id, ex_q.rs)) fwd_a = FWD_MEM;
         else if (wr_hit(wb_q.valid, wb_q.wr_en, wb_q.wr_id, ex_q.rs))          fwd_a = FWD_WB;
         else if (wr_hit(ret_q.valid, ret_q.wr_en, ret_q.wr_id, ex_q.rs))       fwd_a = FWD_RET;
      end
      if (ex_q.valid && ex_q.urt) begin
         if (wr_hit(mem_q.valid, mem_q.wr_en & !mem_q.ld, mem_q.wr_id, ex_q.rt)) fwd_b = FWD_MEM;
         else if (wr_hit(wb_q.valid, wb_q.wr_en, wb_q.wr_id, ex_q.rt))          fwd_b = FWD_WB;
         else if (wr_hit(ret_q.valid, ret_q.wr_en, ret_q.wr_id, ex_q.rt))       fwd_b = FWD_RET;
      end
   end

   // Slot advance; a timed-out access leaves MEM as a dead slot
   always_comb begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      ret_d = ret_q;
      if (!freeze) begin
         ret_d = wb_q;
         wb_d  = mem_err ? '0 : mem_q;
         mem_d = ex_q;
         ex_d  = (bubble_ex || flush_if_id || !id_valid) ? '0 : id_slot;
      end
   end

   // Scoreboard registers
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
         ret_q <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
         ret_q <= ret_d;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl.
module tb_hazard_ctrl;

   typedef struct packed {
      logic       v;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       urs;
      logic       urt;
      logic       jr;
      logic       rw;
      logic [4:0] wr;
      logic       ld;
      logic       st;
   } id_t;

   typedef struct packed {
      logic       stall;
      logic       bubble;
      logic       flush;
      logic       frz;
      logic       req;
      logic       err;
      logic [1:0] fa;
      logic [1:0] fb;
   } exp_t;

   logic       sys_clk = 1'b0;
   logic       rst = 1'b1;
   logic       id_valid = 1'b0;
   logic [4:0] id_rs_id = '0;
   logic [4:0] id_rt_id = '0;
   logic       id_uses_rs = 1'b0;
   logic       id_uses_rt = 1'b0;
   logic       id_is_jr = 1'b0;
   logic       id_reg_write = 1'b0;
   logic [4:0] id_wr_id = '0;
   logic       id_mem_to_reg = 1'b0;
   logic       id_mem_write = 1'b0;
   logic       ex_redirect = 1'b0;
   logic       dmem_ready = 1'b1;
   logic       stall_if_id, bubble_ex, flush_if_id, freeze, dmem_req, mem_err;
   logic [1:0] fwd_a, fwd_b;

   exp_t  exp_q[$];
   string name_q[$];
   int    n_checks = 0;
   int    n_pass = 0;

   localparam exp_t Z = '0;

   hazard_ctrl #(.MEM_TIMEOUT(16), .TO_W(5)) dut (
      .sys_clk       (sys_clk),
      .rst           (rst),
      .id_valid      (id_valid),
      .id_rs_id      (id_rs_id),
      .id_rt_id      (id_rt_id),
      .id_uses_rs    (id_uses_rs),
      .id_uses_rt    (id_uses_rt),
      .id_is_jr      (id_is_jr),
      .id_reg_write  (id_reg_write),
      .id_wr_id      (id_wr_id),
      .id_mem_to_reg (id_mem_to_reg),
      .id_mem_write  (id_mem_write),
      .ex_redirect   (ex_redirect),
      .dmem_ready    (dmem_ready),
      .stall_if_id   (stall_if_id),
      .bubble_ex     (bubble_ex),
      .flush_if_id   (flush_if_id),
      .freeze        (freeze),
      .dmem_req      (dmem_req),
      .fwd_a         (fwd_a),
      .fwd_b         (fwd_b),
      .mem_err       (mem_err)
   );

   always #5 sys_clk = ~sys_clk;

   function automatic id_t nop();
      return '0;
   endfunction

   function automatic id_t alu(input logic [4:0] wr, input logic [4:0] rs, input logic [4:0] rt);
      id_t i = '0;
      i.v = 1'b1; i.rs = rs; i.rt = rt; i.urs = 1'b1; i.urt = 1'b1; i.rw = 1'b1; i.wr = wr;
      return i;
   endfunction

   function automatic id_t lw(input logic [4:0] wr, input logic [4:0] base);
      id_t i = '0;
      i.v = 1'b1; i.rs = base; i.rt = wr; i.urs = 1'b1; i.rw = 1'b1; i.wr = wr; i.ld = 1'b1;
      return i;
   endfunction

   function automatic id_t sw(input logic [4:0] base, input logic [4:0] src);
      id_t i = '0;
      i.v = 1'b1; i.rs = base; i.rt = src; i.urs = 1'b1; i.urt = 1'b1; i.st = 1'b1;
      return i;
   endfunction

   function automatic id_t jr(input logic [4:0] rs);
      id_t i = '0;
      i.v = 1'b1; i.rs = rs; i.urs = 1'b1; i.jr = 1'b1;
      return i;
   endfunction

   // args: stall, bubble, flush, freeze, req, err, fwd_a, fwd_b
   function automatic exp_t mk(input logic s, input logic b, input logic f, input logic z,
                               input logic r, input logic e, input logic [1:0] fa,
                               input logic [1:0] fb);
      exp_t x;
      x.stall = s; x.bubble = b; x.flush = f; x.frz = z; x.req = r; x.err = e; x.fa = fa; x.fb = fb;
      return x;
   endfunction

   // One cycle of stimulus; the expected outputs for that cycle go to the scoreboard
   task automatic step(input id_t i, input logic redir, input logic rdy, input logic rst_v,
                       input logic chk, input exp_t e, input string nm);
      @(posedge sys_clk);
      #1;
      rst           = rst_v;
      id_valid      = i.v;
      id_rs_id      = i.rs;
      id_rt_id      = i.rt;
      id_uses_rs    = i.urs;
      id_uses_rt    = i.urt;
      id_is_jr      = i.jr;
      id_reg_write  = i.rw;
      id_wr_id      = i.wr;
      id_mem_to_reg = i.ld;
      id_mem_write  = i.st;
      ex_redirect   = redir;
      dmem_ready    = rdy;
      if (chk) begin
         exp_q.push_back(e);
         name_q.push_back(nm);
      end
   endtask

   task automatic drain();
      repeat (4) step(nop(), 1'b0, 1'b1, 1'b0, 1'b1, Z, "drain");
   endtask

   // Monitor: compare DUT outputs mid-cycle against the queued expectation
   always @(negedge sys_clk) begin
      exp_t  e;
      exp_t  got;
      string nm;
      if (exp_q.size() != 0) begin
         e   = exp_q.pop_front();
         nm  = name_q.pop_front();
         got = {stall_if_id, bubble_ex, flush_if_id, freeze, dmem_req, mem_err, fwd_a, fwd_b};
         n_checks++;
         if (got === e) n_pass++;
         else $display("FAIL %s @%0t: stall/bub/flush/frz/req/err/fa/fb got=%b required=%b",
                       nm, $time, got, e);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      step(nop(), 1'b0, 1'b1, 1'b1, 1'b0, Z, "rst");
      step(nop(), 1'b0, 1'b1, 1'b1, 1'b0, Z, "rst");
      step(nop(), 1'b0, 1'b1, 1'b0, 1'b1, Z, "reset_state");

      // back-to-back producer/consumer: MEM forward
      step(alu(3, 1, 2), 1'b0, 1'b1, 1'b0, 1'b1, Z, "a_prod");
      step(alu(4, 3, 1), 1'b0, 1'b1, 1'b0, 1'b1, Z, "a_cons");
      step(nop(), 1'b0, 1'b1, 1'b0, 1'b1, mk(0,0,0,0,0,0,2'b01,2'b00), "fwd_mem");
      drain();

      // one unrelated in between: WB forward on rt
      step(alu(7, 1, 2),   1'b0, 1'b1, 1'b0, 1'b1, Z, "b_prod");
      step(alu(8, 9, 10),  1'b0, 1'b1, 1'b0, 1'b1, Z, "b_mid");
      step(alu(11, 1, 7),  1'b0, 1'b1, 1'b0, 1'b1, Z, "b_cons");
      step(nop(), 1'b0, 1'b1, 1'b0, 1'b1, mk(0,0,0,0,0,0,2'b00,2'b10), "fwd_wb");
      drain();

      // two in between: retired forward on both operands
      step(alu(12, 1, 2),   1'b0, 1'b1, 1'b0, 1'b1, Z, "c_prod");
      step(alu(13, 1, 2),   1'b0, 1'b1, 1'b0, 1'b1, Z, "c_mid1");
      step(alu(14, 1, 2),   1'b0, 1'b1, 1'b0, 1'b1, Z, "c_mid2");
      step(alu(15, 12, 12), 1'b0, 1'b1, 1'b0, 1'b1, Z, "c_cons");
      step(nop(), 1'b0, 1'b1, 1'b0, 1'b1, mk(0,0,0,0,0,0,2'b11,2'b11), "fwd_ret");
      drain();

      // youngest producer wins; $0 source never forwards
      step(alu(16, 1, 2), 1'b0, 1'b1, 1'b0, 1'b1, Z, "d_old");
      step(alu(16, 2, 1), 1'b0, 1'b1, 1'b0, 1'b1, Z, "d_young");
      step(alu(17, 16, 0), 1'b0, 1'b1, 1'b0, 1'b1, Z, "d_cons");
      step(nop(), 1'b0, 1'b1, 1'b0, 1'b1, mk(0,0,0,0,0,0,2'b01,2'b00), "fwd_youngest");
      drain();

      // load-use: one stall cycle then WB forward
      step(lw(5, 1),     1'b0, 1'b1, 1'b0, 1'b1, Z, "e_lw");
      step(alu(6, 5, 1), 1'b0, 1'b1, 1'b0, 1'b1, mk(1,1,0,0,0,0,2'b00,2'b00), "load_use_stall");
      step(alu(6, 5, 1), 1'b0, 1'b1, 1'b0, 1'b1, mk(0,0,0,0,1,0,2'b00,2'b00), "load_use_release");
      step(nop(), 1'b0, 1'b1, 1'b0, 1'b1, mk(0,0,0,0,0,0,2'b10,2'b00), "load_use_fwd");
      drain();

      // load into $0 never stalls
      step(lw(0, 1),     1'b0, 1'b1, 1'b0, 1'b1, Z, "f_lw0");
      step(alu(6, 0, 0), 1'b0, 1'b1, 1'b0, 1'b1, Z, "no_stall_r0");
      step(nop(), 1'b0, 1'b1, 1'b0, 1'b1, mk(0,0,0,0,1,0,2'b00,2'b00), "r0_no_fwd");
      drain();

      // redirect overrides a concurrent load-use stall
      step(lw(5, 1),     1'b0, 1'b1, 1'b0, 1'b1, Z, "g_lw");
      step(alu(6, 5, 1), 1'b1, 1'b1, 1'b0, 1'b1, mk(0,1,1,0,0,0,2'b00,2'b00), "redirect_wins");
      step(nop(), 1'b0, 1'b1, 1'b0, 1'b1, mk(0,0,0,0,1,0,2'b00,2'b00), "redirect_after");
      drain();

      // jr waits on EX writer then on MEM load
      step(lw(9, 1), 1'b0, 1'b1, 1'b0, 1'b1, Z, "h_lw");
      step(jr(9),    1'b0, 1'b1, 1'b0, 1'b1, mk(1,1,0,0,0,0,2'b00,2'b00), "jr_ex_stall");
      step(jr(9),    1'b0, 1'b1, 1'b0, 1'b1, mk(1,1,0,0,1,0,2'b00,2'b00), "jr_mem_stall");
      step(jr(9),    1'b0, 1'b1, 1'b0, 1'b1, Z, "jr_clear");
      step(nop(),    1'b0, 1'b1, 1'b0, 1'b1, mk(0,0,0,0,0,0,2'b11,2'b00), "jr_fwd_ret");
      drain();

      // store waits 3 cycles: frozen slots keep their forwards, redirect ignored
      step(alu(20, 1, 2),   1'b0, 1'b1, 1'b0, 1'b1, Z, "i_prod");
      step(sw(1, 2),        1'b0, 1'b1, 1'b0, 1'b1, Z, "i_sw");
      step(alu(21, 20, 20), 1'b0, 1'b1, 1'b0, 1'b1, Z, "i_cons");
      step(nop(), 1'b0, 1'b0, 1'b0, 1'b1, mk(0,0,0,1,1,0,2'b10,2'b10), "freeze_1");
      step(nop(), 1'b1, 1'b0, 1'b0, 1'b1, mk(0,0,0,1,1,0,2'b10,2'b10), "freeze_2_redir_ignored");
      step(nop(), 1'b0, 1'b0, 1'b0, 1'b1, mk(0,0,0,1,1,0,2'b10,2'b10), "freeze_3");
      step(nop(), 1'b0, 1'b1, 1'b0, 1'b1, mk(0,0,0,0,1,0,2'b10,2'b10), "mem_ready");
      step(nop(), 1'b0, 1'b1, 1'b0, 1'b1, Z, "advanced");
      drain();

      // load times out: 16 frozen cycles, one error pulse, no forward from it
      step(lw(22, 1), 1'b0, 1'b1, 1'b0, 1'b1, Z, "j_lw");
      step(nop(),     1'b0, 1'b1, 1'b0, 1'b1, Z, "j_gap");
      for (int k = 0; k < 16; k++)
         step(alu(23, 22, 22), 1'b0, 1'b0, 1'b0, 1'b1, mk(0,0,0,1,1,0,2'b00,2'b00), "timeout_freeze");
      step(alu(23, 22, 22), 1'b0, 1'b0, 1'b0, 1'b1, mk(0,0,0,0,1,1,2'b00,2'b00), "timeout_err");
      step(nop(), 1'b0, 1'b1, 1'b0, 1'b1, Z, "aborted_no_fwd");
      drain();

      // reset while waiting
      step(sw(1, 2), 1'b0, 1'b1, 1'b0, 1'b1, Z, "k_sw");
      step(nop(),    1'b0, 1'b1, 1'b0, 1'b1, Z, "k_gap");
      step(nop(),    1'b0, 1'b0, 1'b0, 1'b1, mk(0,0,0,1,1,0,2'b00,2'b00), "k_freeze");
      step(nop(),    1'b0, 1'b0, 1'b1, 1'b1, mk(0,0,0,1,1,0,2'b00,2'b00), "k_wait_rst");
      step(nop(),    1'b0, 1'b0, 1'b0, 1'b1, Z, "rst_wait_idle");
      step(nop(),    1'b0, 1'b0, 1'b0, 1'b1, Z, "rst_wait_no_err");
      drain();

      repeat (2) @(posedge sys_clk);
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
